byte_serializer: RTL and testbench

//  - Parallel-in/serial-out stage that directly drives the select input of the mux_8x1 sub-module.
//  - Captures one 8-bit word per handshake.
//  - Steps a 3-bit bit index through the word, one bit per accepted serial beat.
//  - Presents each bit with valid/last framing to the downstream bit sink.

---
 rtl/serdes_pkg.sv | 12 +
 rtl/mux_8x1.sv | 14 +
 rtl/byte_serializer.sv | 71 +++++++
 tb/tb_byte_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared widths and state encoding for the byte serializer datapath.
package serdes_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } ser_state_t;

endpackage

// File: rtl/mux_8x1.sv
// Eight-to-one bit selector; y follows i[s].
module mux_8x1
    import serdes_pkg::*;
(
    input  logic [WORD_W-1:0] i,
    input  logic [IDX_W-1:0]  s,
    output logic              y
);

    always_comb begin
        y = i[s];
    end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in/serial-out stage: captures one byte per load handshake and emits it one bit per
// accepted beat with valid/last framing.
module byte_serializer
    import serdes_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    input  logic              ser_ready,
    output logic              busy
);

    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(WORD_W - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(WORD_W - 1);

    ser_state_t        state_q;
    logic [WORD_W-1:0] hold_q;
    logic [IDX_W-1:0]  idx_q;
    logic              in_shift;
    logic              mux_y;
    logic              load_accept;
    logic              beat_accept;

    mux_8x1 u_mux (
        .i (hold_q),
        .s (idx_q),
        .y (mux_y)
    );

    // Outputs are forced quiet while rst is asserted, not just after the reset edge.
    always_comb begin
        in_shift    = (state_q == SHIFT) && !rst;
        ser_valid   = in_shift;
        busy        = in_shift;
        ser_last    = in_shift && (idx_q == LAST_IDX);
        ser_out     = in_shift ? mux_y : IDLE_LEVEL;
        load_ready  = !rst && ((state_q == IDLE) || (ser_last && ser_ready));
        load_accept = load_valid && load_ready;
        beat_accept = ser_valid && ser_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else if (load_accept) begin
            // Covers both IDLE capture and the zero-bubble reload on the final beat.
            state_q <= SHIFT;
            hold_q  <= load_data;
            idx_q   <= FIRST_IDX;
        end else if (beat_accept) begin
            if (ser_last) begin
                state_q <= IDLE;
            end else if (MSB_FIRST) begin
                idx_q <= idx_q - IDX_W'(1);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are compared against
// a bit-queue reference model.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic load_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
    logic load_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Remaining bits of the word in flight, in emission order.
    bit q_l[$];
    bit q_m[$];

    logic obs_out_l, obs_out_m, obs_valid_l, obs_last_l, obs_last_m, obs_lr;

    always #5 clk = ~clk;

    byte_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_l),
        .ser_out    (ser_out_l),
        .ser_valid  (ser_valid_l),
        .ser_last   (ser_last_l),
        .ser_ready  (ser_ready),
        .busy       (busy_l)
    );

    byte_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_m),
        .ser_out    (ser_out_m),
        .ser_valid  (ser_valid_m),
        .ser_last   (ser_last_m),
        .ser_ready  (ser_ready),
        .busy       (busy_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare #1 later, advance the model at posedge.
    task automatic cycle(input logic r, input logic lv, input logic [7:0] ld, input logic sr);
        logic ev, elast_l, elast_m, eout_l, eout_m, elr, beat, lacc;
        @(negedge clk);
        rst        = r;
        load_valid = lv;
        load_data  = ld;
        ser_ready  = sr;
        #1;
        if (r) begin
            ev = 0; elast_l = 0; elast_m = 0; eout_l = 0; eout_m = 0; elr = 0;
        end else begin
            ev      = q_l.size() > 0;
            eout_l  = ev ? q_l[0] : 1'b0;
            eout_m  = ev ? q_m[0] : 1'b0;
            elast_l = q_l.size() == 1;
            elast_m = q_m.size() == 1;
            elr     = (q_l.size() == 0) || ((q_l.size() == 1) && sr);
        end
        check("lsb.load_ready", load_ready_l, elr);
        check("lsb.ser_valid", ser_valid_l, ev);
        check("lsb.ser_out", ser_out_l, eout_l);
        check("lsb.ser_last", ser_last_l, elast_l);
        check("lsb.busy", busy_l, ev);
        check("msb.load_ready", load_ready_m, elr);
        check("msb.ser_valid", ser_valid_m, ev);
        check("msb.ser_out", ser_out_m, eout_m);
        check("msb.ser_last", ser_last_m, elast_m);
        obs_out_l   = ser_out_l;
        obs_out_m   = ser_out_m;
        obs_valid_l = ser_valid_l;
        obs_last_l  = ser_last_l;
        obs_last_m  = ser_last_m;
        obs_lr      = load_ready_l;
        beat = ev && sr;
        lacc = lv && elr;
        @(posedge clk);
        if (r) begin
            q_l.delete();
            q_m.delete();
        end else begin
            if (beat) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (lacc) begin
                for (int k = 0; k < 8; k++) begin
                    q_l.push_back(ld[k]);
                    q_m.push_back(ld[7-k]);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] cap;
        int         nlast;
        int         nvalid;

        rst = 1'b1; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;

        // Reset held with load_valid high.
        cycle(1'b1, 1'b1, 8'h11, 1'b1);
        cycle(1'b1, 1'b1, 8'h22, 1'b1);
        check("reset.load_ready", obs_lr, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_reset.load_ready", obs_lr, 1'b1);

        // Single word LSB first.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        cap = '0; nlast = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'hFF, 1'b1);
            cap[i] = obs_out_l;
            if (obs_last_l) nlast++;
            if (i == 7) check("a5.last_on_8th", obs_last_l, 1'b1);
        end
        check("a5.bits", cap, 8'hA5);
        check("a5.last_count", nlast, 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("a5.idle_after", obs_valid_l, 1'b0);

        // Backpressure on the 2nd bit for 3 cycles: 11 cycles total.
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'hFF, 1'b0);
            check("bp.held_bit", obs_out_l, 1'b0);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("bp.idle_after_11", obs_valid_l, 1'b0);

        // Back-to-back A5 then 3C with load_valid held high.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        nvalid = 0; nlast = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, (i < 8), 8'h3C, 1'b1);
            if (obs_valid_l) nvalid++;
            if (obs_last_l) nlast++;
            if (i == 7) check("b2b.load_ready_beat8", obs_lr, 1'b1);
            if (i == 15) check("b2b.last_beat16", obs_last_l, 1'b1);
        end
        check("b2b.valid_beats", nvalid, 16);
        check("b2b.last_count", nlast, 2);

        // Mid-word reset after 4 beats of FF, then 01 from bit 0.
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("midrst.valid_dropped", obs_valid_l, 1'b0);
        cycle(1'b0, 1'b1, 8'h01, 1'b1);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            cap[i] = obs_out_l;
        end
        check("midrst.next_word", cap, 8'h01);

        // MSB-first instance on 0x80.
        cycle(1'b0, 1'b1, 8'h80, 1'b1);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            cap[7-i] = obs_out_m;
            if (i == 7) check("msb.last_at_sel0", obs_last_m, 1'b1);
        end
        check("msb.bits", cap, 8'h80);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                  8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
